// File: rtl/traffic_sensor_if.sv
// Signal bundle between the loop-detector front end and the sensor conditioner.
// No valid/ready: every signal is a level. raw_* are asynchronous; all outputs change only on posedge clk.
interface traffic_sensor_if;
  logic       raw_a;
  logic       raw_b;
  logic       Sa;
  logic       Sb;
  logic       fault_a;
  logic       fault_b;
  // Lane FSM state for observation: 0 IDLE, 1 ACTIVE, 2 HOLD, 3 FAULT
  logic [1:0] state_a;
  logic [1:0] state_b;

  modport master (
    output raw_a, raw_b,
    input  Sa, Sb, fault_a, fault_b, state_a, state_b
  );

  modport slave (
    input  raw_a, raw_b,
    output Sa, Sb, fault_a, fault_b, state_a, state_b
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the two raw vehicle-loop detector lines into clean Sa/Sb requests:
// synchronize, debounce, bridge short gaps, and drop requests from a stuck detector.
module traffic_sensor_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output logic       s,
  output logic       fault,
  output logic [1:0] state
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int AW = $clog2(STUCK_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES);
  localparam logic [AW-1:0] STUCK_LAST = AW'(STUCK_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  state_t        state_q, state_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          s_q, s_d;
  logic          fault_q, fault_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;

    // The filtered level flips on the edge the disagreement run would reach DEBOUNCE_CYCLES.
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync2_q != deb_q) begin
      if (dcnt_q == DEB_LAST) deb_d = ~deb_q;
      else                    dcnt_d = dcnt_q + 1'b1;
    end

    state_d = state_q;
    acnt_d  = acnt_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      IDLE: begin
        if (deb_q) begin
          state_d = ACTIVE;
          acnt_d  = '0;
        end
      end
      ACTIVE: begin
        acnt_d = acnt_q + 1'b1;
        if (!deb_q) begin
          if (HOLD_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            hcnt_d  = HOLD_LOAD;
          end
        end else if (acnt_q == STUCK_LAST) begin
          state_d = FAULT;
        end
      end
      HOLD: begin
        hcnt_d = hcnt_q - 1'b1;
        // A returning vehicle wins over hold expiry so S never drops across a short gap.
        if (deb_q) begin
          state_d = ACTIVE;
          acnt_d  = '0;
        end else if (hcnt_q <= HW'(1)) begin
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (!deb_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are a registered decode of the current state, one cycle behind it.
    s_d     = (state_q == ACTIVE) || (state_q == HOLD);
    fault_d = (state_q == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      dcnt_q  <= '0;
      state_q <= IDLE;
      acnt_q  <= '0;
      hcnt_q  <= '0;
      s_q     <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      acnt_q  <= acnt_d;
      hcnt_q  <= hcnt_d;
      s_q     <= s_d;
      fault_q <= fault_d;
    end
  end

  assign s     = s_q;
  assign fault = fault_q;
  assign state = state_q;
endmodule

module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 1000
) (
  input logic             clk,
  input logic             rst,
  traffic_sensor_if.slave bus
);
  traffic_sensor_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_lane_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.raw_a),
    .s    (bus.Sa),
    .fault(bus.fault_a),
    .state(bus.state_a)
  );

  traffic_sensor_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_lane_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.raw_b),
    .s    (bus.Sb),
    .fault(bus.fault_b),
    .state(bus.state_b)
  );
endmodule
